sumsub_serial: RTL and testbench
================================

SUMSUB_SERIAL -- requirements
Module: sumsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH % DIGIT != 0 or DIGIT < 1 SHALL fail elaboration.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  operand request.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 sub  in  1  0 = add, 1 = subtract.
REQ-010 c_in  in  1  carry-in (add) or borrow-in (sub), for multiword chaining.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 s  out  WIDTH  result.
REQ-014 c_out  out  1  carry-out (add) or borrow-out (sub).
REQ-015 ovf  out  1  two's-complement signed overflow.
REQ-016 zero  out  1  s == 0.
REQ-017 neg  out  1  s[WIDTH-1].

Function
REQ-018 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-019 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE; both SHALL be state-decoded.
REQ-020 Accept: in IDLE with in_valid = 1 SHALL capture a, b, sub and c_in, clear the digit counter, and enter BUSY.
REQ-021 Initial internal carry SHALL be c_in for add and ~c_in for sub; B SHALL be used as b for add and ~b for sub.
REQ-022 Each BUSY cycle SHALL add the low DIGIT bits of A, B and the carry, shift the DIGIT-bit sum into the result from the MSB side, shift A and B right by DIGIT, and register the digit carry.
REQ-023 After N = WIDTH/DIGIT BUSY cycles, the FSM SHALL enter DONE, and out_valid SHALL rise exactly N cycles after the accept edge.
REQ-024 The add result SHALL be s = (a + b + c_in) mod 2^WIDTH, with c_out = the final carry.
REQ-025 The sub result SHALL be s = (a - b - c_in) mod 2^WIDTH, with c_out = the inverted final carry (the borrow).
REQ-026 ovf SHALL be 1 iff the MSB carry-in differs from the MSB carry-out of the final digit.
REQ-027 zero and neg SHALL be derived from the registered s.
REQ-028 s, c_out, ovf, zero and neg SHALL hold stable throughout DONE.
REQ-029 DONE with out_ready = 1 SHALL return to IDLE on the next edge, giving a throughput of one operation per N+2 cycles.
REQ-030 In BUSY and DONE, in_valid, a, b, sub and c_in SHALL be ignored.
REQ-031 out_ready SHALL be ignored outside DONE.
REQ-032 DIGIT = WIDTH SHALL give N = 1, i.e. a single BUSY cycle.
REQ-033 Operands SHALL be captured only at the accept edge; the source may change them afterward.

Reset
REQ-034 rst = 1 SHALL force IDLE immediately, regardless of clock.
REQ-035 During and after reset, outputs SHALL be: s = 0, c_out = 0, ovf = 0, zero = 0, neg = 0, out_valid = 0, in_ready = 1.
REQ-036 Reset during BUSY or DONE SHALL abort the operation with no result ever presented.
REQ-037 The first accept SHALL be possible on the first edge after rst deasserts.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-038 Add 0x7FFF + 0x0001, c_in = 0 -> s = 0x8000, c_out = 0, ovf = 1, neg = 1, zero = 0; out_valid exactly 4 cycles after accept.
REQ-039 Sub 0x0005 - 0x0007, c_in = 0 -> s = 0xFFFE, c_out = 1, ovf = 0, neg = 1; sub 0x8000 - 0x0001 -> s = 0x7FFF, ovf = 1.
REQ-040 Add 0xFFFF + 0x0000, c_in = 1 -> s = 0x0000, c_out = 1, zero = 1; chained sub with c_in = 1: 0x0000 - 0x0000 -> s = 0xFFFF, c_out = 1.
REQ-041 Hold out_ready = 0 for 5 cycles while driving a new in_valid -> out_valid and all result outputs stable, in_ready = 0, new operands not captured; then out_ready = 1 -> IDLE next cycle, and the new request accepted with its own result.
REQ-042 Assert rst in the second BUSY cycle -> outputs zero and in_ready = 1 immediately, out_valid never asserts for that operation; next op 0x1234 + 0x1111 -> s = 0x2345.
REQ-043 DIGIT = 16 and DIGIT = 1 builds, random operands in both modes vs a reference model -> exact match; latency 1 and 16 respectively.

Source files
------------

// File: rtl/sumsub_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits of A and B per cycle,
// LSB digit first, and presents the WIDTH-bit result with carry/borrow and flags.
module sumsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N     = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if (DIGIT < 1) begin : g_bad_digit
      $error("sumsub_serial: DIGIT must be at least 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
      $error("sumsub_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    acc_r;
  logic                carry_r;
  logic                sub_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-1:0]    s_r;
  logic                c_out_r;
  logic                ovf_r;
  logic                zero_r;
  logic                neg_r;

  logic [DIGIT:0]       digit_sum_s;
  logic [WIDTH+DIGIT-1:0] cat_s;
  logic [WIDTH-1:0]     acc_next_s;
  logic                 msb_cin_s;
  logic                 last_s;

  // One digit of the ripple: sum, carry out, and the carry that entered the digit MSB.
  always_comb begin
    digit_sum_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
    // The carry into the digit MSB is recovered from the sum bit and the two operand bits.
    msb_cin_s   = digit_sum_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    cat_s       = {digit_sum_s[DIGIT-1:0], acc_r};
    acc_next_s  = cat_s[WIDTH+DIGIT-1:DIGIT];
    last_s      = (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, digit shifting and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~c_in; the borrow is the inverted final carry.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~c_in : c_in;
            sub_r   <= sub;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= digit_sum_s[DIGIT];
          acc_r   <= acc_next_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            s_r     <= acc_next_s;
            c_out_r <= digit_sum_s[DIGIT] ^ sub_r;
            ovf_r   <= msb_cin_s ^ digit_sum_s[DIGIT];
            zero_r  <= (acc_next_s == {WIDTH{1'b0}});
            neg_r   <= acc_next_s[WIDTH-1];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign s     = s_r;
  assign c_out = c_out_r;
  assign ovf   = ovf_r;
  assign zero  = zero_r;
  assign neg   = neg_r;

endmodule

// File: tb/tb_sumsub_serial.sv
// Bench for sumsub_serial: three builds (DIGIT 4, 16, 1) share stimulus and are
// compared against an integer-arithmetic reference model.
module tb_sumsub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        sub = 1'b0;
  logic        c_in = 1'b0;
  logic        out_ready = 1'b1;

  logic [2:0]        in_ready_v;
  logic [2:0]        out_valid_v;
  logic [2:0][15:0]  s_v;
  logic [2:0]        c_out_v;
  logic [2:0]        ovf_v;
  logic [2:0]        zero_v;
  logic [2:0]        neg_v;

  int n_chk  = 0;
  int n_pass = 0;
  int lat_exp [3] = '{4, 1, 16};

  logic [15:0] cap_s [3];
  logic        cap_c [3];
  logic        cap_o [3];
  logic        cap_z [3];
  logic        cap_n [3];
  int          cap_lat [3];

  always #5 clk = ~clk;

  sumsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .s(s_v[0]), .c_out(c_out_v[0]), .ovf(ovf_v[0]),
    .zero(zero_v[0]), .neg(neg_v[0]));

  sumsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .s(s_v[1]), .c_out(c_out_v[1]), .ovf(ovf_v[1]),
    .zero(zero_v[1]), .neg(neg_v[1]));

  sumsub_serial #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .s(s_v[2]), .c_out(c_out_v[2]), .ovf(ovf_v[2]),
    .zero(zero_v[2]), .neg(neg_v[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                       input logic mc, output logic [15:0] rs, output logic rc,
                       output logic ro);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ur = ms ? (ua - ub - int'(mc)) : (ua + ub + int'(mc));
    sr = ms ? (sa - sb - int'(mc)) : (sa + sb + int'(mc));
    rs = ur[15:0];
    rc = ms ? (ur < 0) : (ur > 65535);
    ro = (sr > 32767) || (sr < -32768);
  endtask

  task automatic wait_all_idle(input string tag);
    int k;
    k = 0;
    while (in_ready_v != 3'b111 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) check_val({tag, "_idle_timeout"}, 32'(in_ready_v), 32'h7);
  endtask

  // Runs one operation on all builds with out_ready high and checks every build.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input logic tc);
    logic [15:0] es;
    logic ec, eo;
    logic [2:0] seen;
    model(ta, tb_, ts, tc, es, ec, eo);
    wait_all_idle(tag);
    a = ta; b = tb_; sub = ts; c_in = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    seen = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cap_lat[i] = 0; cap_s[i] = 16'h0; cap_c[i] = 1'b0; cap_o[i] = 1'b0;
      cap_z[i] = 1'b0; cap_n[i] = 1'b0;
    end
    for (int cyc = 1; cyc <= 40 && seen != 3'b111; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid_v[i]) begin
          seen[i] = 1'b1;
          cap_lat[i] = cyc;
          cap_s[i] = s_v[i]; cap_c[i] = c_out_v[i]; cap_o[i] = ovf_v[i];
          cap_z[i] = zero_v[i]; cap_n[i] = neg_v[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s_d%0d_lat", tag, i), 32'(cap_lat[i]), 32'(lat_exp[i]));
      check_val($sformatf("%s_d%0d_s", tag, i), 32'(cap_s[i]), 32'(es));
      check_val($sformatf("%s_d%0d_cout", tag, i), 32'(cap_c[i]), 32'(ec));
      check_val($sformatf("%s_d%0d_ovf", tag, i), 32'(cap_o[i]), 32'(eo));
      check_val($sformatf("%s_d%0d_zero", tag, i), 32'(cap_z[i]), 32'(es == 16'h0));
      check_val($sformatf("%s_d%0d_neg", tag, i), 32'(cap_n[i]), 32'(es[15]));
    end
  endtask

  initial begin
    logic [15:0] es;
    logic ec, eo;
    logic [15:0] held_s;
    logic held_c, held_o, held_z, held_n, ov_seen;

    // Reset values while reset is asserted.
    #12;
    check_val("rst_s", 32'(s_v[0]), 32'h0);
    check_val("rst_flags", {27'h0, c_out_v[0], ovf_v[0], zero_v[0], neg_v[0], out_valid_v[0]}, 32'h0);
    check_val("rst_in_ready", 32'(in_ready_v), 32'h7);
    @(negedge clk);
    rst = 1'b0;

    // First accept on the first edge after reset release.
    a = 16'h0001; b = 16'h0002; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("first_accept", 32'(in_ready_v[0]), 32'h0);

    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check_val("add_ovf_const_s", 32'(cap_s[0]), 32'h8000);
    check_val("add_ovf_const_fl", {28'h0, cap_c[0], cap_o[0], cap_n[0], cap_z[0]}, 32'h6);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0);
    check_val("sub_neg_const", {15'h0, cap_s[0], cap_c[0]}, {15'h0, 16'hFFFE, 1'b1});
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
    check_val("sub_ovf_const", {15'h0, cap_s[0], cap_o[0]}, {15'h0, 16'h7FFF, 1'b1});
    do_op("add_wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    check_val("add_wrap_const", {14'h0, cap_s[0], cap_c[0], cap_z[0]}, {14'h0, 16'h0000, 2'b11});
    do_op("sub_chain", 16'h0000, 16'h0000, 1'b1, 1'b1);
    check_val("sub_chain_const", {15'h0, cap_s[0], cap_c[0]}, {15'h0, 16'hFFFF, 1'b1});

    // Back-pressure: result must hold while a new request is ignored.
    wait_all_idle("stall");
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
    end
    check_val("stall_valid", 32'(out_valid_v[0]), 32'h1);
    held_s = s_v[0]; held_c = c_out_v[0]; held_o = ovf_v[0]; held_z = zero_v[0]; held_n = neg_v[0];
    check_val("stall_s", 32'(held_s), 32'h3333);
    a = 16'h4321; b = 16'h0100; sub = 1'b1; c_in = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      check_val($sformatf("stall_hold%0d", cyc),
                {8'h0, out_valid_v[0], in_ready_v[0], s_v[0], c_out_v[0], ovf_v[0], zero_v[0], neg_v[0]},
                {8'h0, 1'b1, 1'b0, held_s, held_c, held_o, held_z, held_n});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("stall_release", {30'h0, out_valid_v[0], in_ready_v[0]}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
    end
    check_val("stall_new_valid", 32'(out_valid_v[0]), 32'h1);
    check_val("stall_new_s", 32'(s_v[0]), 32'h4221);

    // Reset in the second BUSY cycle aborts the operation.
    wait_all_idle("abort");
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("abort_hs", {30'h0, out_valid_v[0], in_ready_v[0]}, 32'h1);
    check_val("abort_out", {11'h0, s_v[0], c_out_v[0], ovf_v[0], zero_v[0], neg_v[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | out_valid_v[0];
    end
    check_val("abort_no_result", 32'(ov_seen), 32'h0);
    do_op("post_abort", 16'h1234, 16'h1111, 1'b0, 1'b0);
    check_val("post_abort_const", 32'(cap_s[0]), 32'h2345);

    // Random operands in both modes on all three builds.
    for (int t = 0; t < 40; t++) begin
      do_op($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    // Model sanity against fixed arithmetic.
    model(16'h0003, 16'h0004, 1'b1, 1'b1, es, ec, eo);
    check_val("model_sanity", {14'h0, es, ec, eo}, {14'h0, 16'hFFFE, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
